operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 134 +++++++++++++
 tb/tb_operand_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand loader: debounces an "enter" key and steps through
// LOAD_A -> LOAD_B -> RUN -> DONE, latching two operands from the switches
// and handshaking one multiply with the downstream controller.
module operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned WIDTH           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             load_key,
  input  logic             mul_done,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             start,
  output logic             busy,
  output logic             result_valid,
  output logic [1:0]       phase
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    RUN    = 2'b10,
    DONE   = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               result_valid_q, result_valid_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               db_q, db_d;
  logic               db_prev_q, db_prev_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               press_c;

  // Synchronizer, mismatch-run debounce counter and rising-edge press detect
  always_comb begin
    s1_d      = load_key;
    s2_d      = s1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    cnt_d     = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 32'd1)) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_c = db_q & ~db_prev_q;
  end

  // Next-state and registered-output logic of the load/run sequencer
  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    start_d        = 1'b0;
    busy_d         = busy_q;
    result_valid_d = result_valid_q;
    unique case (state_q)
      LOAD_A, DONE: begin
        if (press_c) begin
          op_a_d         = sw;
          result_valid_d = 1'b0;
          state_d        = LOAD_B;
        end
      end
      LOAD_B: begin
        if (press_c) begin
          op_b_d  = sw;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        // A done level seen during the start cycle belongs to a stale request
        if (mul_done && !start_q) begin
          result_valid_d = 1'b1;
          busy_d         = 1'b0;
          state_d        = DONE;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= LOAD_A;
      op_a_q         <= '0;
      op_b_q         <= '0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      db_q           <= 1'b0;
      db_prev_q      <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      db_q           <= db_d;
      db_prev_q      <= db_prev_d;
      cnt_q          <= cnt_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign phase        = 2'(state_q);

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed table, hand-written timing sequences,
// and random stimulus compared against a behavioural model.
module tb_operand_loader;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw = '0;
  logic         load_key = 1'b0;
  logic         mul_done = 1'b0;
  logic [W-1:0] op_a, op_b;
  logic         start, busy, result_valid;
  logic [1:0]   phase;

  operand_loader #(.DEBOUNCE_CYCLES(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sw(sw), .load_key(load_key), .mul_done(mul_done),
    .op_a(op_a), .op_b(op_b), .start(start), .busy(busy),
    .result_valid(result_valid), .phase(phase)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  logic prev_start = 1'b0;
  int   start_count = 0;

  // Behavioural model: debounced level flips once the last N synchronized
  // samples all disagree with it; the sequencer follows the phase rules.
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_start = 0, m_busy = 0, m_rv = 0;
  logic [1:0]   m_ph = 2'd0;
  logic         m_s1 = 0, m_s2 = 0, m_db = 0, m_dbp = 0;
  logic         hist[$];

  always @(posedge clk) begin
    if (reset) begin
      m_a = '0; m_b = '0; m_start = 0; m_busy = 0; m_rv = 0; m_ph = 2'd0;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0;
      hist.delete();
    end else begin
      logic press, nstart, all_diff;
      press  = m_db && !m_dbp;
      nstart = 1'b0;
      case (m_ph)
        2'd0, 2'd3: if (press) begin m_a = sw; m_rv = 0; m_ph = 2'd1; end
        2'd1: if (press) begin m_b = sw; nstart = 1; m_busy = 1; m_ph = 2'd2; end
        default: if (mul_done && !m_start) begin m_rv = 1; m_busy = 0; m_ph = 2'd3; end
      endcase
      m_start = nstart;
      m_dbp = m_db;
      hist.push_back(m_s2);
      if (hist.size() > N) void'(hist.pop_front());
      all_diff = (hist.size() == N);
      foreach (hist[i]) if (hist[i] == m_db) all_diff = 1'b0;
      if (all_diff) begin
        m_db = !m_db;
        hist.delete();
      end
      m_s2 = m_s1;
      m_s1 = load_key;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; samples 2ns after the edge and polices start pulse spacing
  task automatic tick();
    @(posedge clk);
    #2;
    if (start) begin
      start_count++;
      chk("start_not_back_to_back", {31'd0, prev_start}, 32'd0);
    end
    prev_start = start;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; load_key = 1'b0; mul_done = 1'b0;
    ticks(3);
    reset = 1'b0;
  endtask

  task automatic press(input logic [W-1:0] v);
    sw = v; load_key = 1'b1;
    ticks(N + 6);
    load_key = 1'b0;
    ticks(N + 6);
  endtask

  task automatic done_pulse();
    mul_done = 1'b1; tick();
    mul_done = 1'b0; tick();
  endtask

  typedef struct {
    int         act;   // 0 press, 1 mul_done pulse, 2 reset
    logic [W-1:0] sw;
    logic [W-1:0] ea, eb;
    logic [1:0] eph;
    logic       erv, ebusy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 16'h1234, 16'h1234, 16'h0000, 2'd1, 1'b0, 1'b0};
    tbl[1] = '{0, 16'h00FF, 16'h1234, 16'h00FF, 2'd2, 1'b0, 1'b1};
    tbl[2] = '{1, 16'h0000, 16'h1234, 16'h00FF, 2'd3, 1'b1, 1'b0};
    tbl[3] = '{0, 16'hFFFF, 16'hFFFF, 16'h00FF, 2'd1, 1'b0, 1'b0};
    tbl[4] = '{0, 16'hA5A5, 16'hFFFF, 16'hA5A5, 2'd2, 1'b0, 1'b1};
    tbl[5] = '{0, 16'h1111, 16'hFFFF, 16'hA5A5, 2'd2, 1'b0, 1'b1};
    tbl[6] = '{2, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0};
    tbl[7] = '{1, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);

    // Directed table
    for (int v = 0; v < 8; v++) begin
      case (tbl[v].act)
        0: press(tbl[v].sw);
        1: done_pulse();
        default: do_reset();
      endcase
      chk($sformatf("tbl%0d_op_a", v), 32'(op_a), 32'(tbl[v].ea));
      chk($sformatf("tbl%0d_op_b", v), 32'(op_b), 32'(tbl[v].eb));
      chk($sformatf("tbl%0d_phase", v), 32'(phase), 32'(tbl[v].eph));
      chk($sformatf("tbl%0d_rv", v), 32'(result_valid), 32'(tbl[v].erv));
      chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].ebusy));
      chk($sformatf("tbl%0d_start", v), 32'(start), 32'd0);
    end

    // Key-to-latch latency: rise just before edge 1, latch at edge 3+N
    do_reset();
    ticks(2);
    sw = 16'hBEEF; load_key = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("lat_e%0d_op_a", k), 32'(op_a), (k < 7) ? 32'd0 : 32'h0000BEEF);
      chk($sformatf("lat_e%0d_phase", k), 32'(phase), (k < 7) ? 32'd0 : 32'd1);
    end
    load_key = 1'b0;
    ticks(N + 6);

    // Bounce rejection then a sustained hold giving one press
    do_reset();
    sw = 16'h5A5A;
    for (int r = 0; r < 5; r++) begin
      load_key = 1'b1; ticks(3);
      load_key = 1'b0; tick();
      chk($sformatf("bounce%0d_phase", r), 32'(phase), 32'd0);
    end
    load_key = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("bounce_e%0d_phase", k), 32'(phase), (k < 7) ? 32'd0 : 32'd1);
    end
    ticks(20);
    chk("held_one_press_phase", 32'(phase), 32'd1);
    chk("held_one_press_op_a", 32'(op_a), 32'h5A5A);
    load_key = 1'b0;
    ticks(N + 6);

    // Key held through reset release: one press after debounce
    reset = 1'b1; load_key = 1'b1; ticks(4);
    reset = 1'b0; sw = 16'h0042;
    ticks(30);
    chk("rst_held_phase", 32'(phase), 32'd1);
    chk("rst_held_op_a", 32'(op_a), 32'h0042);
    load_key = 1'b0;
    ticks(N + 6);

    // Basic flow: one start, busy for 10 cycles, done ignored in start cycle
    do_reset();
    press(16'h1234);
    start_count = 0;
    begin
      int busy_cnt, guard;
      sw = 16'h00FF; load_key = 1'b1;
      guard = 0;
      while (!start && guard < 40) begin tick(); guard++; end
      chk("flow_start_seen", 32'(start), 32'd1);
      busy_cnt = busy ? 1 : 0;
      mul_done = 1'b1;
      tick();
      mul_done = 1'b0; load_key = 1'b0;
      chk("flow_done_in_start_ignored", 32'(phase), 32'd2);
      if (busy) busy_cnt++;
      for (int i = 2; i <= 9; i++) begin
        tick();
        if (busy) busy_cnt++;
      end
      mul_done = 1'b1; tick(); mul_done = 1'b0;
      chk("flow_busy_cycles", 32'(busy_cnt), 32'd10);
      chk("flow_busy_low", 32'(busy), 32'd0);
      chk("flow_phase", 32'(phase), 32'd3);
      chk("flow_rv", 32'(result_valid), 32'd1);
      chk("flow_op_a", 32'(op_a), 32'h1234);
      chk("flow_op_b", 32'(op_b), 32'h00FF);
      ticks(N + 6);
      chk("flow_start_count", 32'(start_count), 32'd1);
    end

    // Random stimulus against the model
    do_reset();
    begin
      int hold;
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
        if (hold == 0) begin
          load_key = 1'($urandom_range(0, 1));
          hold = $urandom_range(1, 12);
        end
        hold--;
        mul_done = ($urandom_range(0, 7) == 0);
        sw = W'($urandom);
        reset = ($urandom_range(0, 499) == 0);
        tick();
        checks++;
        if ({op_a, op_b, start, busy, result_valid, phase} !==
            {m_a, m_b, m_start, m_busy, m_rv, m_ph}) begin
          errors++;
          $display("FAIL rand_c%0d: got a=%h b=%h st=%b bz=%b rv=%b ph=%0d expected a=%h b=%h st=%b bz=%b rv=%b ph=%0d",
                   c, op_a, op_b, start, busy, result_valid, phase,
                   m_a, m_b, m_start, m_busy, m_rv, m_ph);
        end
      end
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
